// File: rtl/requant_stream.sv
// Three-stage streaming requantizer: out = sat(((x + zero) * mult) >>> shift).
// Define REQUANT_ROUND_EN for round-half-up; otherwise results truncate toward -inf.
module requant_stream #(
  parameter int IN_W   = 32,
  parameter int OUT_W  = 8,
  parameter int MULT_W = 32,
  parameter int ZERO_W = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     clear,
  input  logic signed [ZERO_W-1:0] cfg_zero,
  input  logic signed [MULT_W-1:0] cfg_mult,
  input  logic        [5:0]        cfg_shift,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [IN_W-1:0]   in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_last,
  output logic                     sat_flag
);
  localparam int AW     = IN_W + 1;
  localparam int PW     = AW + MULT_W;
  localparam int RW     = PW + 1;   // headroom for the rounding add
  localparam int STAGES = 3;

  localparam logic signed [RW-1:0] MAXV = RW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [RW-1:0] MINV = ~MAXV;

  typedef struct packed {
    logic signed [AW-1:0]     a;
    logic signed [MULT_W-1:0] mult;
    logic        [5:0]        shift;
    logic                     last;
  } s1_t;

  typedef struct packed {
    logic signed [PW-1:0] p;
    logic        [5:0]    shift;
    logic                 last;
  } s2_t;

  s1_t                s1;
  s2_t                s2;
  logic [STAGES-1:0]  vld_pipe;
  logic               adv, acc;

  assign out_valid = vld_pipe[STAGES-1];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv && !clear && rstn;
  assign acc       = in_valid && in_ready;

  logic signed [RW-1:0]    sum, shr;
  logic signed [OUT_W-1:0] clamped;
  logic                    sat;

  always_comb begin
    sum = RW'(s2.p);
`ifdef REQUANT_ROUND_EN
    if (s2.shift != 6'd0) sum = sum + (RW'(1) <<< (s2.shift - 6'd1));
`endif
    shr     = sum >>> s2.shift;
    sat     = 1'b0;
    clamped = shr[OUT_W-1:0];
    if (shr > MAXV) begin
      sat     = 1'b1;
      clamped = MAXV[OUT_W-1:0];
    end else if (shr < MINV) begin
      sat     = 1'b1;
      clamped = MINV[OUT_W-1:0];
    end
  end

  // Data registers follow adv only; validity lives solely in vld_pipe, so clear
  // can leave stale data behind without harm.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_pipe <= '0;
      s1       <= '0;
      s2       <= '0;
      out_data <= '0;
      out_last <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      if (clear)    vld_pipe <= '0;
      else if (adv) vld_pipe <= {vld_pipe[STAGES-2:0], acc};
      if (adv) begin
        s1.a     <= AW'(in_data) + AW'(cfg_zero);
        s1.mult  <= cfg_mult;
        s1.shift <= cfg_shift;
        s1.last  <= in_last;
        s2.p     <= PW'(s1.a) * PW'(s1.mult);
        s2.shift <= s1.shift;
        s2.last  <= s1.last;
        out_data <= clamped;
        out_last <= s2.last;
        sat_flag <= sat;
      end
    end
  end
endmodule

// File: tb/tb_requant_stream.sv
// Scoreboard bench for requant_stream; honours REQUANT_ROUND_EN like the RTL.
module tb_requant_stream;
  localparam int IN_W = 32, OUT_W = 8, MULT_W = 32, ZERO_W = 16;
  localparam logic signed [MULT_W-1:0] CMULT = 32'sh00447EE7;
  localparam logic signed [ZERO_W-1:0] CZERO = -16'sd4;
`ifdef REQUANT_ROUND_EN
  localparam int E100 = 26, E3 = 0;
`else
  localparam int E100 = 25, E3 = -1;
`endif

  logic                     clk, rstn, clear;
  logic signed [ZERO_W-1:0] cfg_zero;
  logic signed [MULT_W-1:0] cfg_mult;
  logic        [5:0]        cfg_shift;
  logic                     in_valid, in_ready, in_last;
  logic signed [IN_W-1:0]   in_data;
  logic                     out_valid, out_ready, out_last, sat_flag;
  logic signed [OUT_W-1:0]  out_data;

  typedef struct packed {
    logic signed [OUT_W-1:0] d;
    logic                    last;
    logic                    sat;
  } exp_t;

  exp_t sb[$];
  int   compared = 0, mismatched = 0, popped = 0;

  requant_stream #(.IN_W(IN_W), .OUT_W(OUT_W), .MULT_W(MULT_W), .ZERO_W(ZERO_W)) dut (
    .clk(clk), .rstn(rstn), .clear(clear), .cfg_zero(cfg_zero), .cfg_mult(cfg_mult),
    .cfg_shift(cfg_shift), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .sat_flag(sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic exp_t mk(input int d, input logic l, input logic s);
    exp_t e;
    e.d = OUT_W'(d); e.last = l; e.sat = s;
    return e;
  endfunction

  // Reference model in 128-bit arithmetic.
  function automatic exp_t model(input logic signed [IN_W-1:0] x, input logic signed [ZERO_W-1:0] z,
                                 input logic signed [MULT_W-1:0] m, input logic [5:0] sh, input logic l);
    logic signed [127:0] v, hi, lo;
    exp_t e;
    hi = (128'sd1 <<< (OUT_W - 1)) - 128'sd1;
    lo = -hi - 128'sd1;
    v  = 128'(x) + 128'(z);
    v  = v * 128'(m);
`ifdef REQUANT_ROUND_EN
    if (sh != 0) v = v + (128'sd1 <<< (sh - 1));
`endif
    v = v >>> sh;
    e.sat  = (v > hi) || (v < lo);
    e.d    = (v > hi) ? hi[OUT_W-1:0] : ((v < lo) ? lo[OUT_W-1:0] : v[OUT_W-1:0]);
    e.last = l;
    return e;
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn && out_valid && out_ready && !clear) begin
        compared++;
        if (sb.size() == 0) begin
          mismatched++;
          $display("FAIL out_unexpected: got d=%0d last=%b, required no beat", out_data, out_last);
        end else begin
          e = sb.pop_front();
          popped++;
          if (out_data !== e.d || out_last !== e.last || sat_flag !== e.sat) begin
            mismatched++;
            $display("FAIL out_beat: got d=%0d last=%b sat=%b, required d=%0d last=%b sat=%b",
                     out_data, out_last, sat_flag, e.d, e.last, e.sat);
          end
        end
      end
    end
  endtask

  // Drive one beat, hold until accepted, optionally record its expected output.
  task automatic send(input logic signed [IN_W-1:0] x, input logic signed [ZERO_W-1:0] z,
                      input logic signed [MULT_W-1:0] m, input logic [5:0] sh, input logic l,
                      input exp_t e, input bit push);
    int t = 0;
    in_valid = 1'b1; in_data = x; cfg_zero = z; cfg_mult = m; cfg_shift = sh; in_last = l;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    compared++;
    if (!in_ready) begin
      mismatched++;
      $display("FAIL send_accept: in_ready=%b after %0d cycles, required 1", in_ready, t);
    end else if (push) sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk); #1;
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL %s_drain: %0d beats outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  // Beat presented before the accepting edge must be visible after the third edge.
  task automatic check_latency(input logic signed [IN_W-1:0] x, input exp_t e, input string name);
    int n = 1;
    in_valid = 1'b1; in_data = x; cfg_zero = CZERO; cfg_mult = CMULT; cfg_shift = 6'd24; in_last = 1'b0;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (n < 10) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      n++;
    end
    compared++;
    if (n != 3) begin
      mismatched++;
      $display("FAIL %s_latency: got %0d cycles, required 3", name, n);
    end
    drain(name);
  endtask

  task automatic test_reset();
    rstn = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    cfg_zero = CZERO; cfg_mult = CMULT; cfg_shift = 6'd24; out_ready = 1'b1;
    #12;
    compared++;
    if ({out_valid, out_last, sat_flag, in_ready} !== 4'b0000 || out_data !== '0) begin
      mismatched++;
      $display("FAIL reset_state: got vld=%b last=%b sat=%b rdy=%b d=%0d, required all 0",
               out_valid, out_last, sat_flag, in_ready, out_data);
    end
    @(negedge clk); rstn = 1'b1;
    #1;
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_release_ready: got %b, required 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    check_latency(100, mk(E100, 0, 0), "v100");
    send(1000,  CZERO, CMULT, 24, 1'b0, mk(127, 0, 1),  1);
    send(-1000, CZERO, CMULT, 24, 1'b1, mk(-128, 1, 1), 1);
    send(3,     CZERO, CMULT, 24, 1'b0, mk(E3, 0, 0),   1);
    send(4,     CZERO, CMULT, 24, 1'b0, mk(0, 0, 0),    1);
    drain("vectors");
  endtask

  task automatic test_backpressure();
    int   p0 = popped;
    bit   first_seen = 0, holding = 0;
    exp_t h;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(50 + 37 * i, CZERO, CMULT, 24, i == 5, model(50 + 37 * i, CZERO, CMULT, 24, i == 5), 1);
      end
      begin
        for (int c = 1; c <= 12; c++) begin
          out_ready = !(c >= 4 && c <= 9);
          @(negedge clk);
          if (out_valid && !out_ready) begin
            if (!first_seen) begin
              first_seen = 1;
              compared++;
              if (in_ready !== 1'b0 || c != 4) begin
                mismatched++;
                $display("FAIL bp_in_ready: cycle %0d in_ready=%b, required cycle 4 in_ready=0", c, in_ready);
              end
            end
            if (holding) begin
              compared++;
              if (out_data !== h.d || out_last !== h.last || sat_flag !== h.sat) begin
                mismatched++;
                $display("FAIL bp_hold: got d=%0d last=%b, required d=%0d last=%b", out_data, out_last, h.d, h.last);
              end
            end
            holding = 1; h.d = out_data; h.last = out_last; h.sat = sat_flag;
          end else holding = 0;
          if (c == 9) begin
            compared++;
            if (sb.size() != 3) begin
              mismatched++;
              $display("FAIL bp_held: got %0d beats in flight, required 3", sb.size());
            end
          end
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b1;
    drain("bp");
    compared++;
    if (popped - p0 != 6) begin
      mismatched++;
      $display("FAIL bp_count: got %0d beats delivered, required 6", popped - p0);
    end
  endtask

  task automatic test_cfg_change();
    send(100, CZERO, CMULT, 24, 1'b0, mk(E100, 0, 0), 1);
    send(5,   16'sd0, 32'sd1, 0, 1'b1, mk(5, 1, 0),   1);
    drain("cfg");
  endtask

  task automatic test_clear();
    bit seen = 0;
    send(100, CZERO, CMULT, 24, 1'b0, mk(0, 0, 0), 0);
    send(200, CZERO, CMULT, 24, 1'b0, mk(0, 0, 0), 0);
    clear = 1'b1; in_valid = 1'b1; in_data = 300;
    @(negedge clk);
    compared++;
    if (in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL clear_ready: got %b, required 0", in_ready);
    end
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    compared++;
    if (seen) begin
      mismatched++;
      $display("FAIL clear_flush: out_valid seen=1, required 0");
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(1000, CZERO, CMULT, 24, 1'b1, mk(0, 0, 0), 0);
    @(negedge clk);
    compared++;
    if (out_valid !== 1'b1 || out_data !== 8'sd127) begin
      mismatched++;
      $display("FAIL rstmid_pre: got vld=%b d=%0d, required vld=1 d=127", out_valid, out_data);
    end
    #2 rstn = 1'b0;
    #1;
    compared++;
    if ({out_valid, out_last, sat_flag} !== 3'b000 || out_data !== '0) begin
      mismatched++;
      $display("FAIL rstmid_async: got vld=%b last=%b sat=%b d=%0d, required all 0",
               out_valid, out_last, sat_flag, out_data);
    end
    @(negedge clk); rstn = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    check_latency(100, mk(E100, 0, 0), "rstmid");
  endtask

  task automatic test_back_to_back();
    bit done = 0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          logic signed [IN_W-1:0]   x;
          logic signed [ZERO_W-1:0] z;
          logic signed [MULT_W-1:0] m;
          logic        [5:0]        sh;
          logic                     l;
          x  = $urandom();
          z  = ZERO_W'($urandom());
          m  = (i % 3 == 0) ? CMULT : $urandom();
          sh = 6'($urandom_range(0, 63));
          l  = (i % 7 == 6);
          send(x, z, m, sh, l, model(x, z, m, sh, l), 1);
        end
        done = 1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b1;
    drain("b2b");
  endtask

  initial begin
    fork monitor(); join_none
    test_reset();
    test_vectors();
    test_backpressure();
    test_cfg_change();
    test_clear();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
